plab4_net_router_output_ctrl_pkt: RTL and testbench
===================================================

# plab4_net_router_output_ctrl_pkt

Parametrised, packet-aware output-port controller for the plab4 network router. It arbitrates among `p_num_ports` input queues for one router output using round-robin arbitration. Once a head flit wins, the output stays locked to that input until its tail flit transfers. All arbitration state (priority pointer, lock flag, lock owner) is kept separately per security domain, so one domain's traffic history never affects another domain's grant timing. It replaces the fixed 3-input, flit-level output control in the router datapath and drives the crossbar select.

## Interface
- `p_num_ports`, 3: number of requesting inputs, 2..8.
- `p_num_domains`, 2: number of security domains time-multiplexed on the router, 1..4.
- `p_sel_nbits`, $clog2(p_num_ports): width of `xbar_sel`.
- `p_sd_nbits`, max(1,$clog2(p_num_domains)): width of `cur_sd`.
- `clk`  in  1  router clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all per-domain state immediately.
- `cur_sd`  in  p_sd_nbits  domain currently owning the router; selects the state context. Values ≥ p_num_domains are never driven.
- `reqs`  in  p_num_ports  per-input request (head-of-queue flit valid for this output).
- `tails`  in  p_num_ports  per-input flag: head-of-queue flit is a tail; single-flit packets assert it.
- `grants`  out  p_num_ports  one-hot or zero; a grant means the flit transfers this cycle.
- `out_val`  out  1  `|grants`.
- `out_rdy`  in  1  downstream ready.
- `xbar_sel`  out  p_sel_nbits  index of granted input; p_num_ports-1 when no grant.

## Operation
- Per-domain context d holds three fields: `ptr[d]` (index of the highest-priority input), `locked[d]`, and `owner[d]`. Reset values are 0, 0 and 0 for every d.
- Only context `cur_sd` is read or updated in a given cycle. All other contexts hold.
- Grant rule is purely combinational from the state, `reqs`, `tails`, `out_rdy` and `cur_sd`:
  - If `out_rdy`=0, then `grants`=0.
  - Otherwise, if `locked`, the grant goes to `owner` when `reqs[owner]`=1; otherwise `grants`=0. An owner bubble does not release the lock.
  - Otherwise, the grant goes to the first requesting input found scanning from `ptr`, `ptr`+1, … modulo p_num_ports.
- State update on a transfer (grant to input i):
  - `tails[i]`=0: set `locked`=1 and `owner`=i; `ptr` is unchanged.
  - `tails[i]`=1: set `locked`=0 and `ptr`=(i+1) mod p_num_ports. If p_num_ports is not a power of two, the wrap must not overflow.
- No transfer leaves the state unchanged.
- A `cur_sd` change mid-packet does not disturb the lock. The lock resumes exactly when the domain's slot returns, so packets are never interleaved on an output.

## Timing
- Grant, `out_val` and `xbar_sel` have zero latency from `reqs`/`out_rdy`.
- State updates take effect the cycle after the transfer.
- Reset asserted mid-packet drops the lock immediately and asynchronously. Outputs revert the same cycle to free arbitration from `ptr`=0.
- A packet of k flits with `out_rdy` held at 1 and the owner never bubbling occupies exactly k consecutive cycles.
- No output depends combinationally on any domain other than `cur_sd`.

## Structure
- Shared package `plab4_net_RouterPkg`: `p_sel_nbits` and `p_sd_nbits` derivation functions, plus a one-hot-to-index function reused by the input controllers.
- One sub-module is natural: `plab4_net_RrPickVar`. It is a combinational round-robin pick, taking `reqs` and `ptr` and returning a one-hot grant, parametrised on p_num_ports.
- The per-domain registers are arrays indexed by `cur_sd`, kept in the top module.

## Test plan
- **Single-flit fairness:** N=3, one domain, `reqs`=111, `tails`=111, `out_rdy`=1 for 6 cycles. Required `grants`: 001, 010, 100, 001, 010, 100; `xbar_sel`: 0, 1, 2, 0, 1, 2.
- **Packet lock:** input 0 sends a 3-flit packet (`tails`=0,0,1) while input 1 requests continuously. Required `grants`: 001, 001, 001, then 010.
- **Bubble and backpressure:**
  - Locked to input 2 with `reqs[2]` dropped for 2 cycles. Required: `grants`=0 while inputs 0 and 1 request; input 2 resumes on its return.
  - `out_rdy`=0 for 1 cycle. Required: `grants`=0 and state unchanged.
- **Domain isolation:**
  - Domain 0 is locked to input 1 after a head flit. Switch `cur_sd` to 1 with `reqs`=011. Required: domain 1 grants input 0 (its own `ptr`=0).
  - Switch back to domain 0. Required: input 1 is granted and finishes its packet.
- **Async reset mid-packet:** N=5, locked to input 3. Assert `reset` mid-cycle. Required: state clears immediately. After release with `reqs`=11000, the grant goes to input 3 from `ptr`=0.
- **Non-power-of-two wrap:** N=5, tail transfer from input 4. Required: next `ptr`=0.

Source files
------------

// File: rtl/plab4_net_router_output_ctrl_pkt_pkg.sv
// Shared router helpers: parameter width derivations and one-hot decode.
package plab4_net_RouterPkg;

  function automatic int sel_nbits(input int num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

  function automatic int sd_nbits(input int num_domains);
    return (num_domains <= 1) ? 1 : $clog2(num_domains);
  endfunction

  // Callers guarantee at most one bit set; an all-zero vector decodes to 0.
  function automatic int onehot_to_idx(input logic [7:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_pkt_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module plab4_net_RrPickVar
  import plab4_net_RouterPkg::*;
#(
  parameter int p_num_ports = 3,
  parameter int p_sel_nbits = sel_nbits(p_num_ports)
) (
  input  logic [p_num_ports-1:0] reqs,
  input  logic [p_sel_nbits-1:0] ptr,
  output logic [p_num_ports-1:0] grants
);

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    grants = '0;
    for (int off = 0; off < p_num_ports; off++) begin
      idx = int'(ptr) + off;
      if (idx >= p_num_ports) idx = idx - p_num_ports;
      if (!found && reqs[idx]) begin
        grants[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl_pkt.sv
// Packet-aware output controller: round-robin arbitration with per-domain
// priority pointer and wormhole lock so packets never interleave on the output.
module plab4_net_router_output_ctrl_pkt
  import plab4_net_RouterPkg::*;
#(
  parameter int p_num_ports   = 3,
  parameter int p_num_domains = 2,
  parameter int p_sel_nbits   = sel_nbits(p_num_ports),
  parameter int p_sd_nbits    = sd_nbits(p_num_domains)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_sd_nbits-1:0]  cur_sd,
  input  logic [p_num_ports-1:0] reqs,
  input  logic [p_num_ports-1:0] tails,
  output logic [p_num_ports-1:0] grants,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_sel_nbits-1:0] xbar_sel
);

  // Context arrays cover the full cur_sd range so indexing is always in bounds.
  localparam int p_num_ctx = 1 << p_sd_nbits;
  localparam logic [p_sel_nbits-1:0] c_last = p_sel_nbits'(p_num_ports - 1);

  logic [p_sel_nbits-1:0] ptr_q   [p_num_ctx];
  logic                   locked_q[p_num_ctx];
  logic [p_sel_nbits-1:0] owner_q [p_num_ctx];

  logic [p_sel_nbits-1:0] cur_ptr;
  logic                   cur_locked;
  logic [p_sel_nbits-1:0] cur_owner;
  logic [p_num_ports-1:0] rr_grants;

  assign cur_ptr    = ptr_q[cur_sd];
  assign cur_locked = locked_q[cur_sd];
  assign cur_owner  = owner_q[cur_sd];

  plab4_net_RrPickVar #(
    .p_num_ports (p_num_ports),
    .p_sel_nbits (p_sel_nbits)
  ) rr_pick (
    .reqs   (reqs),
    .ptr    (cur_ptr),
    .grants (rr_grants)
  );

  // An owner bubble yields no grant rather than releasing the lock.
  always_comb begin
    grants = '0;
    if (out_rdy) begin
      if (cur_locked) begin
        if (reqs[cur_owner]) grants[cur_owner] = 1'b1;
      end else begin
        grants = rr_grants;
      end
    end
  end

  assign out_val  = |grants;
  assign xbar_sel = out_val ? p_sel_nbits'(onehot_to_idx(8'(grants))) : c_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < p_num_ctx; d++) begin
        ptr_q[d]    <= '0;
        locked_q[d] <= 1'b0;
        owner_q[d]  <= '0;
      end
    end else if (out_val) begin
      if (tails[xbar_sel]) begin
        locked_q[cur_sd] <= 1'b0;
        ptr_q[cur_sd]    <= (xbar_sel == c_last) ? '0 : xbar_sel + 1'b1;
      end else begin
        locked_q[cur_sd] <= 1'b1;
        owner_q[cur_sd]  <= xbar_sel;
      end
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_pkt.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares against the three-port and five-port instances.
module tb_plab4_net_router_output_ctrl_pkt;

  typedef struct {
    logic       big;     // 0: three-port/two-domain instance, 1: five-port instance
    logic [4:0] grants;
    logic [2:0] sel;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rdy_a = 1'b0;
  logic [0:0] sd_a  = '0;
  logic [2:0] reqs_a = '0, tails_a = '0, grants_a;
  logic [1:0] sel_a;
  logic       val_a;

  logic       rst_b = 1'b1, rdy_b = 1'b0;
  logic [0:0] sd_b  = '0;
  logic [4:0] reqs_b = '0, tails_b = '0, grants_b;
  logic [2:0] sel_b;
  logic       val_b;

  plab4_net_router_output_ctrl_pkt #(.p_num_ports(3), .p_num_domains(2)) dut (
    .clk(clk), .reset(rst_a), .cur_sd(sd_a), .reqs(reqs_a), .tails(tails_a),
    .grants(grants_a), .out_val(val_a), .out_rdy(rdy_a), .xbar_sel(sel_a)
  );

  plab4_net_router_output_ctrl_pkt #(.p_num_ports(5), .p_num_domains(1)) dut5 (
    .clk(clk), .reset(rst_b), .cur_sd(sd_b), .reqs(reqs_b), .tails(tails_b),
    .grants(grants_b), .out_val(val_b), .out_rdy(rdy_b), .xbar_sel(sel_b)
  );

  task automatic step_a(input string name, input logic sd, input logic [2:0] r,
                        input logic [2:0] t, input logic rdy,
                        input logic [2:0] eg, input logic [2:0] es);
    exp_t x;
    @(posedge clk); #1;
    sd_a = sd; reqs_a = r; tails_a = t; rdy_a = rdy;
    x.big = 1'b0; x.grants = {2'b00, eg}; x.sel = es; x.name = name;
    sb.push_back(x);
  endtask

  task automatic step_b(input string name, input logic rst, input logic [4:0] r,
                        input logic [4:0] t, input logic [4:0] eg, input logic [2:0] es);
    exp_t x;
    @(posedge clk); #1;
    rst_b = rst; reqs_b = r; tails_b = t; rdy_b = 1'b1;
    x.big = 1'b1; x.grants = eg; x.sel = es; x.name = name;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [4:0] g;
      logic [2:0] s;
      logic       v;
      e = sb.pop_front();
      g = e.big ? grants_b : {2'b00, grants_a};
      s = e.big ? sel_b : {1'b0, sel_a};
      v = e.big ? val_b : val_a;
      n_tests += 3;
      if (g !== e.grants) begin
        n_fail++;
        $display("FAIL %s grants: got %b want %b", e.name, g, e.grants);
      end
      if (s !== e.sel) begin
        n_fail++;
        $display("FAIL %s xbar_sel: got %0d want %0d", e.name, s, e.sel);
      end
      if (v !== (|e.grants)) begin
        n_fail++;
        $display("FAIL %s out_val: got %b want %b", e.name, v, |e.grants);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    step_a("reset_idle", 0, 3'b000, 3'b000, 1, 3'b000, 2);

    // single-flit fairness
    for (int i = 0; i < 6; i++)
      step_a("fair", 0, 3'b111, 3'b111, 1, 3'b001 << (i % 3), 3'(i % 3));

    // 3-flit packet from input 0, input 1 waits; ptr ends at 2
    step_a("lock_head", 0, 3'b011, 3'b010, 1, 3'b001, 0);
    step_a("lock_body", 0, 3'b011, 3'b010, 1, 3'b001, 0);
    step_a("lock_tail", 0, 3'b011, 3'b011, 1, 3'b001, 0);
    step_a("lock_next", 0, 3'b011, 3'b010, 1, 3'b010, 1);

    // lock to input 2, owner bubbles for 2 cycles
    step_a("bub_head", 0, 3'b111, 3'b000, 1, 3'b100, 2);
    step_a("bub_gap0", 0, 3'b011, 3'b000, 1, 3'b000, 2);
    step_a("bub_gap1", 0, 3'b011, 3'b000, 1, 3'b000, 2);
    step_a("bub_tail", 0, 3'b111, 3'b100, 1, 3'b100, 2);

    // backpressure holds ptr at 0
    step_a("bp_stall", 0, 3'b111, 3'b111, 0, 3'b000, 2);
    step_a("bp_go",    0, 3'b111, 3'b111, 1, 3'b001, 0);

    // domain isolation: domain 0 locks to input 1 (ptr=1)
    step_a("iso_d0_head", 0, 3'b010, 3'b000, 1, 3'b010, 1);
    step_a("iso_d1",      1, 3'b011, 3'b011, 1, 3'b001, 0);
    step_a("iso_d0_body", 0, 3'b011, 3'b000, 1, 3'b010, 1);
    step_a("iso_d0_tail", 0, 3'b011, 3'b010, 1, 3'b010, 1);
    step_a("iso_d0_ptr2", 0, 3'b011, 3'b011, 1, 3'b001, 0);
    step_a("iso_d1_ptr1", 1, 3'b011, 3'b011, 1, 3'b010, 1);

    // five ports: lock to input 3, then reset mid-packet
    step_b("n5_head",  0, 5'b01000, 5'b00000, 5'b01000, 3);
    step_b("n5_body",  0, 5'b01000, 5'b00000, 5'b01000, 3);
    step_b("n5_rst",   1, 5'b10000, 5'b00000, 5'b10000, 4);
    step_b("n5_after", 0, 5'b11000, 5'b01000, 5'b01000, 3);
    // ptr=4: tail from input 4 must wrap ptr to 0
    step_b("n5_p4",    0, 5'b11001, 5'b10000, 5'b10000, 4);
    step_b("n5_wrap",  0, 5'b11001, 5'b11111, 5'b00001, 0);

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, want completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
